gpio_pwm_bank: RTL and testbench
================================

Name: gpio_pwm_bank

Overview:
- Bank of GPIO_WIDTH PWM generators that produce the per-pin alternate-function signal for the GPIO pin multiplexer (the sig2 input, selected per pin by the GPIO select mask).
- One shared prescaler and one shared period counter; each channel has its own duty compare.
- Configured over a simple single-cycle register write/read port driven by the wishbone GPIO slave.
- Duty and period updates are double-buffered and take effect at period wrap, so no glitches occur.

Parameters:
- GPIO_WIDTH, 13, number of PWM channels (must be ≤ 28).
- COUNT_WIDTH, 16, width of the prescaler, period and duty registers.
- ADDR_WIDTH, 5, register address width.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- wr_en  input  1  register write strobe, one cycle per write.
- addr  input  ADDR_WIDTH  register address for both read and write.
- wr_data  input  COUNT_WIDTH  write data.
- rd_data  output  COUNT_WIDTH  combinational readback of the register at addr.
- period_wrap  output  1  one-cycle pulse at each period wrap.
- pwm_out  output  GPIO_WIDTH  registered PWM outputs, feeding the pin mux sig2.

Behaviour:
- Reset is asynchronous and active-low. All registers, counters, period_wrap and pwm_out reset to 0.
- Register map:
  - 0 CTRL: bit0 enable.
  - 1 PRESC.
  - 2 PERIOD.
  - 3 POLARITY (feature only).
  - 4+k DUTY[k] for k < GPIO_WIDTH.
  - Unmapped addresses: writes are ignored, reads return 0.
- PRESC takes effect immediately. A write to PRESC also clears the prescaler counter.
- PERIOD and DUTY writes go to pending registers. Active copies load from the pending registers:
  - on the wrap cycle, or
  - on every cycle while enable = 0.
- If a write and a load occur in the same cycle, the newly written value is loaded (bypass).
- rd_data returns the pending values.
- Prescaler:
  - pcnt counts 0..PRESC. tick = (pcnt == PRESC), then pcnt returns to 0.
  - PRESC = 0 gives a tick every clock.
- Period counter:
  - On a tick, cnt increments. wrap = tick && (cnt == active PERIOD), and cnt returns to 0.
  - Effective period = (PERIOD+1)·(PRESC+1) clocks.
  - PERIOD = 0 means cnt stays at 0 and wraps every tick.
- Compare: raw[k] = (cnt < active DUTY[k]).
  - DUTY = 0 gives a constant 0.
  - DUTY > PERIOD gives a constant 1 (100% duty).
  - Unsigned, COUNT_WIDTH-bit compare; no wrap-around arithmetic is possible.
- pwm_out[k] is registered from raw[k], giving 1 clock latency from the cnt change. period_wrap is registered alongside it and is aligned with pwm_out returning high at cnt = 0.
- Enable handling:
  - Clearing enable holds pcnt and cnt at 0 and forces pwm_out to 0 (idle level) on the next clock.
  - Setting enable restarts from cnt = 0 with freshly loaded active values.
- A reset mid-period aborts immediately, and outputs go low asynchronously.

Optional Feature:
- Macro: GPIO_PWM_POLARITY_EN.
- Defined:
  - Address 3 is the POLARITY register (low GPIO_WIDTH bits, reset 0).
  - pwm_out[k] = raw[k] XOR POLARITY[k]. The idle level while disabled is also POLARITY[k].
  - POLARITY takes effect immediately, not shadowed.
- Undefined:
  - Address 3 is unmapped and reads 0.
  - There is no XOR, and the idle level is 0.

Decomposition:
- Shared package gpio_pwm_pkg holds:
  - register address constants: ADDR_CTRL, ADDR_PRESC, ADDR_PERIOD, ADDR_POLARITY, ADDR_DUTY_BASE;
  - the CTRL_ENABLE bit index;
  - default widths.
- One natural sub-module, pwm_compare_chan: per-channel pending/active DUTY, load logic, compare, polarity and output register. It is instantiated GPIO_WIDTH times in a generate loop.
- The top level keeps the prescaler, period counter, address decode and readback mux.

Test Plan:
- Reset, then read all addresses → all reads return 0 and pwm_out = 0. Assert resetn low mid-period → pwm_out is 0 the same cycle.
- PRESC = 0, PERIOD = 9, DUTY[0] = 3, enable → pwm_out[0] is high 3 of every 10 clocks. period_wrap pulses every 10 clocks, aligned with the rising edge.
- PRESC = 1, PERIOD = 4, DUTY[2] = 0 and DUTY[3] = 7:
  - pwm_out[2] is constantly 0 and pwm_out[3] is constantly 1;
  - period is 10 clocks.
- While running with DUTY[0] = 3, write DUTY[0] = 6 mid-period → the old duty completes. The next period is 6 high; no partial or glitch pulse.
- Write DUTY[1] = 5 on exactly the wrap cycle → 5 applies in the immediately following period. Clear enable → pwm_out = 0 next clock and cnt holds at 0.
- With GPIO_PWM_POLARITY_EN: POLARITY = 0x0001, DUTY[0] = 3, PERIOD = 9 → pwm_out[0] is low 3 and high 7 per period. Disabled → pwm_out[0] = 1.

Source files
------------

// File: rtl/gpio_pwm_bank_pkg.sv
// Shared constants for the GPIO PWM bank: register map, CTRL bit layout and default widths.
// Optional polarity register is enabled with the GPIO_PWM_POLARITY_EN macro.
package gpio_pwm_pkg;

   localparam int DEFAULT_GPIO_WIDTH  = 13;
   localparam int DEFAULT_COUNT_WIDTH = 16;
   localparam int DEFAULT_ADDR_WIDTH  = 5;

   localparam int ADDR_CTRL      = 0;
   localparam int ADDR_PRESC     = 1;
   localparam int ADDR_PERIOD    = 2;
   localparam int ADDR_POLARITY  = 3;
   localparam int ADDR_DUTY_BASE = 4;

   localparam int CTRL_ENABLE = 0;

   function automatic int dutyAddr(input int chan);
      return ADDR_DUTY_BASE + chan;
   endfunction

endpackage

// File: rtl/gpio_pwm_bank_if.sv
// Single-cycle register write/read port between the wishbone GPIO slave and the PWM bank.
// Unaffected by GPIO_PWM_POLARITY_EN.
interface gpio_pwm_bank_if
   import gpio_pwm_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
);

   logic                   wr_en;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [COUNT_WIDTH-1:0] wr_data;
   logic [COUNT_WIDTH-1:0] rd_data;

   modport master (output wr_en, addr, wr_data, input  rd_data);
   modport slave  (input  wr_en, addr, wr_data, output rd_data);

endinterface

// File: rtl/gpio_pwm_bank_chan.sv
// One PWM channel: pending/active duty with wrap-time load, compare against the shared count,
// polarity XOR and output register. Polarity is supplied by the top (zero unless GPIO_PWM_POLARITY_EN).
module pwm_compare_chan
   import gpio_pwm_pkg::*;
#(
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   i_wr,
   input  logic [COUNT_WIDTH-1:0] i_wrData,
   input  logic                   i_load,
   input  logic                   i_outEn,
   input  logic                   i_polarity,
   input  logic [COUNT_WIDTH-1:0] i_cnt,
   output logic [COUNT_WIDTH-1:0] o_dutyPend,
   output logic                   o_pwm
);

   logic [COUNT_WIDTH-1:0] r_dutyPend;
   logic [COUNT_WIDTH-1:0] r_dutyAct;
   logic                   r_pwm;
   logic                   w_raw;

   assign w_raw = (i_cnt < r_dutyAct);

   // A write landing on a load cycle goes straight into the active copy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_dutyPend <= '0;
         r_dutyAct  <= '0;
         r_pwm      <= 1'b0;
      end else begin
         if (i_wr) begin
            r_dutyPend <= i_wrData;
         end
         if (i_load) begin
            r_dutyAct <= i_wr ? i_wrData : r_dutyPend;
         end
         r_pwm <= i_outEn ? (w_raw ^ i_polarity) : i_polarity;
      end
   end

   assign o_dutyPend = r_dutyPend;
   assign o_pwm      = r_pwm;

endmodule

// File: rtl/gpio_pwm_bank.sv
// Bank of PWM generators feeding the GPIO pin-mux sig2 inputs: shared prescaler and period
// counter, per-channel compare. Define GPIO_PWM_POLARITY_EN to add the POLARITY register at address 3.
module gpio_pwm_bank
   import gpio_pwm_pkg::*;
#(
   parameter int GPIO_WIDTH  = DEFAULT_GPIO_WIDTH,
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
   parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   gpio_pwm_bank_if.slave        bus,
   output logic                  period_wrap,
   output logic [GPIO_WIDTH-1:0] pwm_out
);

   logic                   r_enable;
   logic [COUNT_WIDTH-1:0] r_presc;
   logic [COUNT_WIDTH-1:0] r_periodPend;
   logic [COUNT_WIDTH-1:0] r_periodAct;
   logic [COUNT_WIDTH-1:0] r_pcnt;
   logic [COUNT_WIDTH-1:0] r_cnt;
   logic                   r_wrapPend;
   logic                   r_periodWrap;

   logic                   w_ctrlWr;
   logic                   w_prescWr;
   logic                   w_periodWr;
   logic                   w_run;
   logic                   w_tick;
   logic                   w_wrap;
   logic                   w_load;
   logic [GPIO_WIDTH-1:0]  w_polarity;
   logic [GPIO_WIDTH-1:0]  w_pwm;
   logic [COUNT_WIDTH-1:0] w_dutyPend [GPIO_WIDTH];
   logic [COUNT_WIDTH-1:0] w_rdData;

   assign w_ctrlWr   = bus.wr_en && (bus.addr == ADDR_WIDTH'(ADDR_CTRL));
   assign w_prescWr  = bus.wr_en && (bus.addr == ADDR_WIDTH'(ADDR_PRESC));
   assign w_periodWr = bus.wr_en && (bus.addr == ADDR_WIDTH'(ADDR_PERIOD));

   // A write clearing enable stops counting and idles the outputs on that same edge.
   assign w_run  = r_enable && !(w_ctrlWr && !bus.wr_data[CTRL_ENABLE]);
   assign w_tick = w_run && (r_pcnt == r_presc);
   assign w_wrap = w_tick && (r_cnt == r_periodAct);
   assign w_load = w_wrap || !r_enable;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_enable     <= 1'b0;
         r_presc      <= '0;
         r_periodPend <= '0;
         r_periodAct  <= '0;
      end else begin
         if (w_ctrlWr) begin
            r_enable <= bus.wr_data[CTRL_ENABLE];
         end
         if (w_prescWr) begin
            r_presc <= bus.wr_data;
         end
         if (w_periodWr) begin
            r_periodPend <= bus.wr_data;
         end
         if (w_load) begin
            r_periodAct <= w_periodWr ? bus.wr_data : r_periodPend;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pcnt <= '0;
         r_cnt  <= '0;
      end else if (!w_run) begin
         r_pcnt <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_prescWr || w_tick) begin
            r_pcnt <= '0;
         end else begin
            r_pcnt <= r_pcnt + COUNT_WIDTH'(1);
         end
         if (w_wrap) begin
            r_cnt <= '0;
         end else if (w_tick) begin
            r_cnt <= r_cnt + COUNT_WIDTH'(1);
         end
      end
   end

   // Two stages so the wrap pulse lines up with pwm_out rising one clock after cnt returns to 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wrapPend   <= 1'b0;
         r_periodWrap <= 1'b0;
      end else begin
         r_wrapPend   <= w_wrap;
         r_periodWrap <= r_wrapPend && w_run;
      end
   end

`ifdef GPIO_PWM_POLARITY_EN
   logic                  w_polWr;
   logic [GPIO_WIDTH-1:0] r_polarity;

   assign w_polWr = bus.wr_en && (bus.addr == ADDR_WIDTH'(ADDR_POLARITY));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_polarity <= '0;
      end else if (w_polWr) begin
         r_polarity <= bus.wr_data[GPIO_WIDTH-1:0];
      end
   end

   assign w_polarity = r_polarity;
`else
   assign w_polarity = '0;
`endif

   for (genvar k = 0; k < GPIO_WIDTH; k++) begin : g_chan
      logic w_dutyWr;

      assign w_dutyWr = bus.wr_en && (bus.addr == ADDR_WIDTH'(dutyAddr(k)));

      pwm_compare_chan #(
         .COUNT_WIDTH (COUNT_WIDTH)
      ) u_chan (
         .clk        (clk),
         .resetn     (resetn),
         .i_wr       (w_dutyWr),
         .i_wrData   (bus.wr_data),
         .i_load     (w_load),
         .i_outEn    (w_run),
         .i_polarity (w_polarity[k]),
         .i_cnt      (r_cnt),
         .o_dutyPend (w_dutyPend[k]),
         .o_pwm      (w_pwm[k])
      );
   end

   always_comb begin
      w_rdData = '0;
      if (bus.addr == ADDR_WIDTH'(ADDR_CTRL)) begin
         w_rdData[CTRL_ENABLE] = r_enable;
      end else if (bus.addr == ADDR_WIDTH'(ADDR_PRESC)) begin
         w_rdData = r_presc;
      end else if (bus.addr == ADDR_WIDTH'(ADDR_PERIOD)) begin
         w_rdData = r_periodPend;
`ifdef GPIO_PWM_POLARITY_EN
      end else if (bus.addr == ADDR_WIDTH'(ADDR_POLARITY)) begin
         w_rdData = COUNT_WIDTH'(r_polarity);
`endif
      end else begin
         for (int k = 0; k < GPIO_WIDTH; k++) begin
            if (bus.addr == ADDR_WIDTH'(dutyAddr(k))) begin
               w_rdData = w_dutyPend[k];
            end
         end
      end
   end

   assign bus.rd_data = w_rdData;
   assign period_wrap = r_periodWrap;
   assign pwm_out     = w_pwm;

endmodule

// File: tb/tb_gpio_pwm_bank.sv
// Directed bench for gpio_pwm_bank: reset, duty/period shadowing, prescaler, enable and reset abort.
// Polarity steps run only when GPIO_PWM_POLARITY_EN is defined.
module tb_gpio_pwm_bank;

   logic        clk;
   logic        resetn;
   logic        period_wrap;
   logic [12:0] pwm_out;
   logic [15:0] rd;
   int          checks;
   int          errors;
   int          n;

   gpio_pwm_bank_if #(.ADDR_WIDTH(5), .COUNT_WIDTH(16)) bus ();

   gpio_pwm_bank #(
      .GPIO_WIDTH  (13),
      .COUNT_WIDTH (16),
      .ADDR_WIDTH  (5)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .bus         (bus),
      .period_wrap (period_wrap),
      .pwm_out     (pwm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(negedge clk);
      n++;
   endtask

   // Register write held for exactly one rising edge; returns on the negedge after it.
   task automatic applyStimulus(input int a, input int d);
      stepCycle();
      bus.wr_en   = 1'b1;
      bus.addr    = 5'(a);
      bus.wr_data = 16'(d);
      stepCycle();
      bus.wr_en   = 1'b0;
   endtask

   task automatic readReg(input int a, output logic [15:0] v);
      bus.addr = 5'(a);
      #1;
      v = bus.rd_data;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      n           = 0;
      resetn      = 1'b0;
      bus.wr_en   = 1'b0;
      bus.addr    = '0;
      bus.wr_data = '0;

      repeat (3) @(negedge clk);
      checkOutput("rstPwm", 32'(pwm_out), 32'h0);
      checkOutput("rstWrap", 32'(period_wrap), 32'h0);
      resetn = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 32; a++) begin
         readReg(a, rd);
         checkOutput($sformatf("rstRd%0d", a), 32'(rd), 32'h0);
      end

      // PRESC=0, PERIOD=9, DUTY0=3: high 3 of 10 clocks, wrap pulse with the rising edge
      applyStimulus(1, 0);
      applyStimulus(2, 9);
      applyStimulus(4, 3);
      applyStimulus(0, 1);
      n = 0;
      checkOutput("aStartPwm0", 32'(pwm_out[0]), 32'h0);
      checkOutput("aStartWrap", 32'(period_wrap), 32'h0);
      for (int i = 1; i <= 30; i++) begin
         stepCycle();
         checkOutput($sformatf("aPwm0_n%0d", n), 32'(pwm_out[0]), 32'((n % 10 >= 1) && (n % 10 <= 3)));
         checkOutput($sformatf("aWrap_n%0d", n), 32'(period_wrap), 32'((n >= 11) && (n % 10 == 1)));
      end

      // DUTY0 -> 6 mid-period: current period finishes at 3, the next one is 6 high
      applyStimulus(4, 6);
      checkOutput("dPwm0_n32", 32'(pwm_out[0]), 32'h1);
      while (n < 60) begin
         stepCycle();
         checkOutput($sformatf("dPwm0_n%0d", n), 32'(pwm_out[0]),
                     (n <= 40) ? 32'(n == 33) : 32'((n % 10 >= 1) && (n % 10 <= 6)));
      end

      // DUTY1=5 written on the wrap cycle (n=69) applies to the period starting right after it
      while (n < 68) stepCycle();
      applyStimulus(5, 5);
      checkOutput("bPwm1_n70", 32'(pwm_out[1]), 32'h0);
      while (n < 80) begin
         stepCycle();
         checkOutput($sformatf("bPwm1_n%0d", n), 32'(pwm_out[1]), 32'((n % 10 >= 1) && (n % 10 <= 5)));
      end
      checkOutput("bWrap_n80", 32'(period_wrap), 32'h0);

      // Clearing enable idles every output on the next clock
      applyStimulus(0, 0);
      checkOutput("disPwm", 32'(pwm_out), 32'h0);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput($sformatf("disPwmHold%0d", i), 32'(pwm_out), 32'h0);
         checkOutput($sformatf("disWrapHold%0d", i), 32'(period_wrap), 32'h0);
      end

      // PRESC=1, PERIOD=4: DUTY2=0 stays low, DUTY3=7 (and DUTY0/1 > PERIOD) stay high; period 10
      applyStimulus(1, 1);
      applyStimulus(2, 4);
      applyStimulus(7, 7);
      applyStimulus(6, 0);
      applyStimulus(0, 1);
      n = 0;
      checkOutput("cStartPwm", 32'(pwm_out), 32'h0);
      for (int i = 1; i <= 30; i++) begin
         stepCycle();
         checkOutput($sformatf("cPwm_n%0d", n), 32'(pwm_out), 32'h00B);
         checkOutput($sformatf("cWrap_n%0d", n), 32'(period_wrap), 32'((n >= 11) && (n % 10 == 1)));
      end

      readReg(0, rd);  checkOutput("rdCtrl", 32'(rd), 32'h1);
      readReg(1, rd);  checkOutput("rdPresc", 32'(rd), 32'h1);
      readReg(2, rd);  checkOutput("rdPeriod", 32'(rd), 32'h4);
      readReg(3, rd);  checkOutput("rdAddr3", 32'(rd), 32'h0);
      readReg(4, rd);  checkOutput("rdDuty0", 32'(rd), 32'h6);
      readReg(5, rd);  checkOutput("rdDuty1", 32'(rd), 32'h5);
      readReg(7, rd);  checkOutput("rdDuty3", 32'(rd), 32'h7);
      readReg(16, rd); checkOutput("rdDuty12", 32'(rd), 32'h0);
      readReg(17, rd); checkOutput("rdUnmap17", 32'(rd), 32'h0);
      readReg(31, rd); checkOutput("rdUnmap31", 32'(rd), 32'h0);
      applyStimulus(17, 16'hBEEF);
      readReg(17, rd); checkOutput("rdUnmapWr", 32'(rd), 32'h0);

      // Reset mid-period drops outputs without waiting for a clock
      stepCycle();
      resetn = 1'b0;
      #1;
      checkOutput("midRstPwm", 32'(pwm_out), 32'h0);
      checkOutput("midRstWrap", 32'(period_wrap), 32'h0);
      @(negedge clk);
      resetn = 1'b1;
      readReg(2, rd); checkOutput("midRstPeriod", 32'(rd), 32'h0);
      readReg(7, rd); checkOutput("midRstDuty3", 32'(rd), 32'h0);
      readReg(0, rd); checkOutput("midRstCtrl", 32'(rd), 32'h0);

`ifdef GPIO_PWM_POLARITY_EN
      // POLARITY bit0: idle high, low 3 / high 7 per period
      applyStimulus(3, 1);
      applyStimulus(1, 0);
      applyStimulus(2, 9);
      applyStimulus(4, 3);
      checkOutput("pIdle", 32'(pwm_out[0]), 32'h1);
      readReg(3, rd); checkOutput("pRdPol", 32'(rd), 32'h1);
      applyStimulus(0, 1);
      n = 0;
      checkOutput("pStart", 32'(pwm_out[0]), 32'h1);
      for (int i = 1; i <= 20; i++) begin
         stepCycle();
         checkOutput($sformatf("pPwm0_n%0d", n), 32'(pwm_out[0]), 32'(!((n % 10 >= 1) && (n % 10 <= 3))));
      end
      applyStimulus(0, 0);
      checkOutput("pDisIdle", 32'(pwm_out[0]), 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
